// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the fetch/load-store requesters, the arbiter and the external memory bus.
// The master modport is the arbiter's view; slave is the environment (requesters plus memory).
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_req;
   logic        d_we;
   logic        d_size;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        err;
   logic        bus_stb;
   logic        bus_we;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, bus_rdata, bus_ack,
      output if_rdata, if_done, d_rdata, d_done, err,
      output bus_stb, bus_we, bus_sel, bus_addr, bus_wdata
   );

   modport slave (
      output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, bus_rdata, bus_ack,
      input  if_rdata, if_done, d_rdata, d_done, err,
      input  bus_stb, bus_we, bus_sel, bus_addr, bus_wdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the data path, with byte-lane handling,
// sign-extended byte loads, a fetch-starvation limit and a bus timeout. All outputs registered.
module mem_port_arbiter #(
   parameter int TIMEOUT     = 16,
   parameter int DATA_STREAK = 4
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master mp
);
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam int SW = $clog2(DATA_STREAK + 1) + 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t        state_q, state_d;
   logic          owner_q, owner_d;   // 1 = fetch owns the bus
   logic          size_q, size_d;
   logic [1:0]    lane_q, lane_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          bus_stb_q, bus_stb_d;
   logic          bus_we_q, bus_we_d;
   logic [3:0]    bus_sel_q, bus_sel_d;
   logic [31:0]   bus_addr_q, bus_addr_d;
   logic [31:0]   bus_wdata_q, bus_wdata_d;
   logic          if_done_q, if_done_d;
   logic          d_done_q, d_done_d;
   logic [31:0]   if_rdata_q, if_rdata_d;
   logic [31:0]   d_rdata_q, d_rdata_d;
   logic          err_q, err_d;
   logic          grant_f;
   logic          misal;

   function automatic logic [31:0] sext_byte(input logic [31:0] word, input logic [1:0] lane);
      logic signed [7:0]  b;
      logic signed [31:0] w;
      b = word[{lane, 3'b000} +: 8];
      w = b;
      return w;
   endfunction

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      size_d      = size_q;
      lane_d      = lane_q;
      tmo_d       = tmo_q;
      streak_d    = streak_q;
      bus_stb_d   = bus_stb_q;
      bus_we_d    = bus_we_q;
      bus_sel_d   = bus_sel_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      if_done_d   = 1'b0;
      d_done_d    = 1'b0;
      if_rdata_d  = 32'h0;
      d_rdata_d   = 32'h0;
      err_d       = 1'b0;
      grant_f     = 1'b0;
      misal       = 1'b0;
      case (state_q)
         IDLE: begin
            if (mp.d_req || mp.if_req) begin
               grant_f = mp.if_req && (!mp.d_req || streak_q == SW'(DATA_STREAK));
               if (grant_f) begin
                  streak_d    = '0;
                  owner_d     = 1'b1;
                  size_d      = 1'b1;
                  lane_d      = mp.if_addr[1:0];
                  misal       = |mp.if_addr[1:0];
                  bus_we_d    = 1'b0;
                  bus_sel_d   = 4'b1111;
                  bus_addr_d  = {mp.if_addr[31:2], 2'b00};
                  bus_wdata_d = 32'h0;
               end else begin
                  if (!mp.if_req)
                     streak_d = '0;
                  else if (streak_q != SW'(DATA_STREAK))
                     streak_d = streak_q + SW'(1);
                  owner_d     = 1'b0;
                  size_d      = mp.d_size;
                  lane_d      = mp.d_addr[1:0];
                  misal       = mp.d_size && (|mp.d_addr[1:0]);
                  bus_we_d    = mp.d_we;
                  bus_sel_d   = mp.d_size ? 4'b1111 : (4'b0001 << mp.d_addr[1:0]);
                  bus_addr_d  = {mp.d_addr[31:2], 2'b00};
                  bus_wdata_d = mp.d_size ? mp.d_wdata : {4{mp.d_wdata[7:0]}};
               end
               if (misal) begin
                  // No bus cycle: report the failure straight away.
                  state_d     = RESP;
                  err_d       = 1'b1;
                  if_done_d   = grant_f;
                  d_done_d    = !grant_f;
                  bus_we_d    = 1'b0;
                  bus_sel_d   = 4'b0000;
                  bus_addr_d  = 32'h0;
                  bus_wdata_d = 32'h0;
               end else begin
                  state_d   = ACCESS;
                  bus_stb_d = 1'b1;
                  tmo_d     = '0;
               end
            end
         end
         ACCESS: begin
            if (mp.bus_ack || tmo_q == TW'(TIMEOUT - 1)) begin
               state_d     = RESP;
               bus_stb_d   = 1'b0;
               bus_we_d    = 1'b0;
               bus_sel_d   = 4'b0000;
               bus_addr_d  = 32'h0;
               bus_wdata_d = 32'h0;
               if_done_d   = owner_q;
               d_done_d    = !owner_q;
               err_d       = !mp.bus_ack;
               if (mp.bus_ack) begin
                  if (owner_q)
                     if_rdata_d = mp.bus_rdata;
                  else if (!bus_we_q)
                     d_rdata_d = size_q ? mp.bus_rdata : sext_byte(mp.bus_rdata, lane_q);
               end
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         size_q      <= 1'b0;
         lane_q      <= 2'b00;
         tmo_q       <= '0;
         streak_q    <= '0;
         bus_stb_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_sel_q   <= 4'b0000;
         bus_addr_q  <= 32'h0;
         bus_wdata_q <= 32'h0;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         if_rdata_q  <= 32'h0;
         d_rdata_q   <= 32'h0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         size_q      <= size_d;
         lane_q      <= lane_d;
         tmo_q       <= tmo_d;
         streak_q    <= streak_d;
         bus_stb_q   <= bus_stb_d;
         bus_we_q    <= bus_we_d;
         bus_sel_q   <= bus_sel_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         if_done_q   <= if_done_d;
         d_done_q    <= d_done_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         err_q       <= err_d;
      end
   end

   assign mp.bus_stb   = bus_stb_q;
   assign mp.bus_we    = bus_we_q;
   assign mp.bus_sel   = bus_sel_q;
   assign mp.bus_addr  = bus_addr_q;
   assign mp.bus_wdata = bus_wdata_q;
   assign mp.if_done   = if_done_q;
   assign mp.d_done    = d_done_q;
   assign mp.if_rdata  = if_rdata_q;
   assign mp.d_rdata   = d_rdata_q;
   assign mp.err       = err_q;
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences the core's single shared memory bus between two requesters: instruction fetch and the data path (load/store driven by the decoder's MemRead/MemWrite/MemSize). It grants one requester at a time, converts byte (8-bit) accesses into lane selects and sign-extended read data, and enforces a bus timeout. It sits between the fetch/load-store stages and the external memory bus.

## Interface
- `TIMEOUT`, default 16: max cycles `bus_stb` waits for `bus_ack` before the access is aborted.
- `DATA_STREAK`, default 4: max back-to-back data grants while fetch is waiting before fetch is forced a grant.
- `clk` in 1: single clock; all state on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state immediately.
- `if_req` in 1: fetch request; held high until `if_done`.
- `if_addr` in 32: fetch address; word access only.
- `if_rdata` out 32: fetched word; valid while `if_done`=1.
- `if_done` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: data request (MemRead|MemWrite); held until `d_done`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_size` in 1: 1 = 32-bit, 0 = 8-bit.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: store data; byte stores use bits [7:0].
- `d_rdata` out 32: load result; byte loads sign-extended; valid while `d_done`=1.
- `d_done` out 1: one-cycle completion pulse for data.
- `err` out 1: high with `if_done`/`d_done` when that access failed (timeout or misalignment).
- `bus_stb` out 1: bus cycle active.
- `bus_we` out 1: bus write.
- `bus_sel` out 4: byte-lane enables.
- `bus_addr` out 32: word-aligned address ({addr[31:2],2'b00}).
- `bus_wdata` out 32: write data.
- `bus_rdata` in 32: read data, sampled when `bus_ack`=1.
- `bus_ack` in 1: slave completion, one cycle.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: if no request, stay. Otherwise arbitrate: data wins unless `if_req`=1 and streak counter = `DATA_STREAK`, then fetch wins. Latch owner, address, we, size, wdata; go ACCESS.
- Streak counter: +1 on each data grant while `if_req`=1 (saturates at `DATA_STREAK`); cleared on any fetch grant and whenever a data grant is made with `if_req`=0.
- Misaligned data word access (`d_size`=1, `d_addr[1:0]`≠0): no bus cycle; IDLE goes straight to RESP with `err`=1, `d_rdata`=0. Fetch addresses with [1:0]≠0 handled identically.
- ACCESS: `bus_stb`=1 with latched fields. Word: `bus_sel`=4'b1111, `bus_wdata`=wdata. Byte: `bus_sel`=1<<addr[1:0], `bus_wdata`={4{wdata[7:0]}}. Fetch always read, sel 4'b1111.
- On `bus_ack`: capture read data (byte: lane addr[1:0] sign-extended to 32; word: as-is), go RESP, `err`=0.
- Timeout counter starts at 0 on ACCESS entry, +1 per cycle without ack; when it reaches `TIMEOUT`-1 without ack, drop `bus_stb` and go RESP with `err`=1, rdata=0. Ack in that same cycle wins (success).
- RESP: pulse owner's done for one cycle, rdata/err valid; return to IDLE. Non-owner done stays 0.
- Stores: `d_rdata`=0 at done.

## Timing
- Reset values: `bus_stb`=0, `bus_we`=0, `bus_sel`=0, `bus_addr`=0, `bus_wdata`=0, `if_done`=`d_done`=0, `if_rdata`=`d_rdata`=0, `err`=0, state IDLE, counters 0.
- All outputs registered. Request seen in IDLE at cycle N -> `bus_stb` high from N+1; ack at cycle M≥N+1 -> done pulse at M+1. Minimum latency 2 cycles request-to-done; misaligned 1 cycle.
- Requester drops request in the cycle after its done; re-arbitration occurs the cycle after RESP, so back-to-back accesses take ≥3 cycles each.
- `bus_ack` outside ACCESS ignored. Requests that change while owned are ignored (latched copy used).
- Reset asserted mid-access: `bus_stb` and dones drop immediately; no done is issued for the aborted access.

## Test plan
- Word load: `d_req`, `d_size`=1, addr 0x100, ack after 2 cycles with 0x12345678 -> `bus_sel`=1111, `bus_addr`=0x100, `d_done` pulse, `d_rdata`=0x12345678, `err`=0.
- Byte load/store: lb at 0x103, bus_rdata 0x80FFFFFF -> `bus_sel`=1000, `d_rdata`=0xFFFFFF80; sb 0xA5 at 0x101 -> `bus_sel`=0010, `bus_wdata`=0xA5A5A5A5, `bus_we`=1.
- Arbitration: both requests held continuously -> grant order D,D,D,D,F,D,D,D,D,F with `DATA_STREAK`=4; fetch alone -> every grant to fetch.
- Timeout: no ack -> `bus_stb` high exactly 16 cycles, then `d_done`+`err`=1, `d_rdata`=0; ack on 16th cycle -> success, `err`=0.
- Misaligned: lw at 0x102 -> no `bus_stb`, `d_done`+`err` next cycle.
- Reset mid-ACCESS: `reset`=0 while `bus_stb`=1 -> all outputs 0 same cycle, no done after release.
